// File: rtl/ps2_keycode_rx_if.sv
// Scancode output bundle of the PS/2 keyboard receiver.
// The receiver drives it through the master modport, and consumers read it through the slave modport.
interface ps2_keycode_rx_if;
  logic [31:0] keycode;
  logic        key_valid;
  logic        key_event;
  logic [7:0]  key_code;
  logic        key_ext;
  logic        key_break;
  logic        frame_err;

  modport master (
    output keycode, key_valid, key_event, key_code, key_ext, key_break, frame_err
  );

  modport slave (
    input keycode, key_valid, key_event, key_code, key_ext, key_break, frame_err
  );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the keyboard lines, deframes
// 11-bit frames, and keeps a 4-byte scancode history plus decoded make/break events.
module ps2_keycode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int TO_W        = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_keycode_rx_if.master  kif
);

  localparam int FC_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return (^b) ^ p;
  endfunction

  logic            clk_sync_p0, clk_sync_p1;
  logic            dat_sync_p0, dat_sync_p1;
  logic            filt_clk, filt_clk_d;
  logic [FC_W-1:0] filt_cnt;
  logic            fall;

  state_t          state, state_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic            par_bit, par_nxt;
  logic [TO_W-1:0] wd_cnt, wd_nxt;
  logic            vld_p0, bad_p0, timeout_p0;
  logic            pend_ext, pend_brk;

  // Stage p0/p1: two-flop synchronizers; lines idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_p0 <= 1'b1;
      clk_sync_p1 <= 1'b1;
      dat_sync_p0 <= 1'b1;
      dat_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0 <= ps2_clk;
      clk_sync_p1 <= clk_sync_p0;
      dat_sync_p0 <= ps2_data;
      dat_sync_p1 <= dat_sync_p0;
    end
  end

  // Filter: a new clock level must be seen on FILTER_LEN consecutive samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_sync_p1 != filt_clk) begin
        if (filt_cnt == FC_W'(FILTER_LEN - 1)) begin
          filt_clk <= clk_sync_p1;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FC_W'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_clk_d & ~filt_clk;

  // Deframing FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      par_bit <= par_nxt;
      wd_cnt  <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par_bit;
    vld_p0      = 1'b0;
    bad_p0      = 1'b0;
    timeout_p0  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fall && !dat_sync_p1) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shreg_nxt = {dat_sync_p1, shreg[7:1]};
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
          else                 bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_nxt   = dat_sync_p1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          if (dat_sync_p1 && odd_parity_ok(shreg, par_bit)) vld_p0 = 1'b1;
          else                                              bad_p0 = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A fall in the same cycle as the limit wins; the frame keeps going
    if (state != S_IDLE && !fall && wd_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
      timeout_p0 = 1'b1;
      state_nxt  = S_IDLE;
    end
    wd_nxt = (fall || state == S_IDLE) ? '0 : wd_cnt + TO_W'(1);
  end

  // Stage p1: commit byte, fold E0/F0 prefixes into the next key event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kif.keycode   <= '0;
      kif.key_valid <= 1'b0;
      kif.key_event <= 1'b0;
      kif.key_code  <= '0;
      kif.key_ext   <= 1'b0;
      kif.key_break <= 1'b0;
      kif.frame_err <= 1'b0;
      pend_ext      <= 1'b0;
      pend_brk      <= 1'b0;
    end else begin
      kif.key_valid <= vld_p0;
      kif.key_event <= 1'b0;
      kif.frame_err <= bad_p0 | timeout_p0;
      if (vld_p0) begin
        kif.keycode <= {kif.keycode[23:0], shreg};
        if (shreg == 8'hE0) begin
          pend_ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          pend_brk <= 1'b1;
        end else begin
          kif.key_event <= 1'b1;
          kif.key_code  <= shreg;
          kif.key_ext   <= pend_ext;
          kif.key_break <= pend_brk;
          pend_ext      <= 1'b0;
          pend_brk      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: drives PS/2 frames bit by bit and checks
// the byte history, key events, frame errors, watchdog timing and reset behaviour.
module tb_ps2_keycode_rx;

  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int TOW  = 9;
  localparam int HALF = 16;
  // Pin-to-register delay of a ps2_clk fall: 2 sync flops + FL filter samples + 1
  localparam int FALL_LAT = 3 + FL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_event = 0;
  int n_err = 0;
  int n_overlap = 0;
  int b_valid, b_event, b_err;

  ps2_keycode_rx_if kif ();

  ps2_keycode_rx #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO),
    .TO_W       (TOW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kif     (kif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kif.key_valid) n_valid++;
    if (kif.key_event) n_event++;
    if (kif.frame_err) n_err++;
    if (kif.frame_err && kif.key_valid) n_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_event = n_event;
    b_err   = n_err;
  endtask

  task automatic drive_bit(input logic v);
    ps2_data = v;
    ps2_clk  = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic line_idle(input int cyc);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit((~^b) ^ par_flip);
    drive_bit(stop);
    line_idle(40);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_keycode"},   kif.keycode,            32'h0);
    chk({tag, "_key_valid"}, {31'd0, kif.key_valid}, 32'h0);
    chk({tag, "_key_event"}, {31'd0, kif.key_event}, 32'h0);
    chk({tag, "_key_code"},  {24'd0, kif.key_code},  32'h0);
    chk({tag, "_key_ext"},   {31'd0, kif.key_ext},   32'h0);
    chk({tag, "_key_break"}, {31'd0, kif.key_break}, 32'h0);
    chk({tag, "_frame_err"}, {31'd0, kif.frame_err}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_outputs_zero("rst");
    rst_n = 1'b1;
    line_idle(10);

    // 1: single make code 1D
    snap();
    send_frame(8'h1D, 1'b0, 1'b1);
    chk("t1_nvalid",  n_valid - b_valid,     32'd1);
    chk("t1_nevent",  n_event - b_event,     32'd1);
    chk("t1_nerr",    n_err - b_err,         32'd0);
    chk("t1_keycode", kif.keycode,           32'h0000001D);
    chk("t1_code",    {24'd0, kif.key_code}, 32'h1D);
    chk("t1_ext",     {31'd0, kif.key_ext},  32'h0);
    chk("t1_brk",     {31'd0, kif.key_break}, 32'h0);

    // 2: break of 1D from a fresh reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    line_idle(10);
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b1);
    chk("t2_nvalid",  n_valid - b_valid,      32'd2);
    chk("t2_nevent",  n_event - b_event,      32'd1);
    chk("t2_keycode", kif.keycode,            32'h0000F01D);
    chk("t2_code",    {24'd0, kif.key_code},  32'h1D);
    chk("t2_brk",     {31'd0, kif.key_break}, 32'h1);
    chk("t2_ext",     {31'd0, kif.key_ext},   32'h0);

    // 3: extended break E0 F0 75, then plain make 72
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("t3_nvalid",  n_valid - b_valid,      32'd3);
    chk("t3_nevent",  n_event - b_event,      32'd1);
    chk("t3_keycode", kif.keycode,            32'h1DE0F075);
    chk("t3_code",    {24'd0, kif.key_code},  32'h75);
    chk("t3_ext",     {31'd0, kif.key_ext},   32'h1);
    chk("t3_brk",     {31'd0, kif.key_break}, 32'h1);
    send_frame(8'h72, 1'b0, 1'b1);
    chk("t3b_keycode", kif.keycode,            32'hE0F07572);
    chk("t3b_code",    {24'd0, kif.key_code},  32'h72);
    chk("t3b_ext",     {31'd0, kif.key_ext},   32'h0);
    chk("t3b_brk",     {31'd0, kif.key_break}, 32'h0);

    // 4: bad parity, then bad stop bit
    snap();
    send_frame(8'h23, 1'b1, 1'b1);
    chk("t4p_nerr",    n_err - b_err,         32'd1);
    chk("t4p_nvalid",  n_valid - b_valid,     32'd0);
    chk("t4p_keycode", kif.keycode,           32'hE0F07572);
    chk("t4p_code",    {24'd0, kif.key_code}, 32'h72);
    snap();
    send_frame(8'h23, 1'b0, 1'b0);
    chk("t4s_nerr",    n_err - b_err,     32'd1);
    chk("t4s_nvalid",  n_valid - b_valid, 32'd0);
    chk("t4s_keycode", kif.keycode,       32'hE0F07572);

    // 5: start + 4 data bits then silence; watchdog fires TO cycles after the last fall
    snap();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (int n = 1; n <= FALL_LAT + TO + 20; n++) begin
      @(negedge clk);
      if (n == HALF) ps2_clk = 1'b1;
      if (n == FALL_LAT + TO - 1) chk("t5_err_early",  {31'd0, kif.frame_err}, 32'h0);
      if (n == FALL_LAT + TO)     chk("t5_err_pulse",  {31'd0, kif.frame_err}, 32'h1);
      if (n == FALL_LAT + TO + 1) chk("t5_err_single", {31'd0, kif.frame_err}, 32'h0);
    end
    chk("t5_nerr",    n_err - b_err,     32'd1);
    chk("t5_nvalid",  n_valid - b_valid, 32'd0);
    chk("t5_keycode", kif.keycode,       32'hE0F07572);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t5_next_keycode", kif.keycode,           32'hF075721C);
    chk("t5_next_code",    {24'd0, kif.key_code}, 32'h1C);

    // 6a: short low glitch on ps2_clk (with data low) must not start a frame
    snap();
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (FL - 2) @(negedge clk);
    line_idle(40);
    chk("t6g_nerr",   n_err - b_err,     32'd0);
    chk("t6g_nvalid", n_valid - b_valid, 32'd0);
    send_frame(8'h29, 1'b0, 1'b1);
    chk("t6g_nerr2",   n_err - b_err,         32'd0);
    chk("t6g_keycode", kif.keycode,           32'h75721C29);
    chk("t6g_code",    {24'd0, kif.key_code}, 32'h29);

    // 6b: reset mid-frame, then a full frame decodes from scratch
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("t6r");
    rst_n = 1'b1;
    line_idle(40);
    snap();
    send_frame(8'h6B, 1'b0, 1'b1);
    chk("t6r_nvalid",  n_valid - b_valid,     32'd1);
    chk("t6r_nerr",    n_err - b_err,         32'd0);
    chk("t6r_keycode", kif.keycode,           32'h0000006B);
    chk("t6r_code",    {24'd0, kif.key_code}, 32'h6B);

    chk("err_valid_overlap", n_overlap, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
